// File: rtl/puf_ctrl.sv
// puf_ctrl: steps the 32-arbiter PUF array through three fixed challenges and majority-votes
// repeated races per bit. The result is a 96-bit device ID plus a count of non-unanimous bits.
module puf_ctrl #(
    parameter int unsigned SAMPLES    = 7,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned EVAL_CYC   = 8,
    parameter logic [31:0] CHAL0      = 32'h5A5A_C3C3,
    parameter logic [31:0] CHAL1      = 32'h0F1E_2D3C,
    parameter logic [31:0] CHAL2      = 32'hA5F0_9E17
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_valid_o,
    output logic [95:0] id_o,
    output logic [6:0]  unstable_o,
    output logic        puf_enable_o,
    output logic [31:0] puf_challenge_o,
    input  logic [31:0] puf_resp_i
);

    localparam int unsigned   TMAX        = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
    localparam int unsigned   TW          = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] EVAL_LAST   = TW'(EVAL_CYC - 1);
    localparam logic [3:0]    SMP_LAST    = 4'(SAMPLES - 1);
    localparam logic [3:0]    SMP_ALL     = 4'(SAMPLES);
    localparam logic [3:0]    MAJORITY    = 4'((SAMPLES + 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EVAL,
        S_VOTE,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [3:0]      smp, smp_n;
    logic [1:0]      ch, ch_n;
    logic            start_run, last_eval, do_vote;
    logic [31:0]     resp_meta, resp_sync;
    logic [3:0]      cnt [32];
    logic [31:0]     vote;
    logic [5:0]      unstable_inc;

    function automatic logic [31:0] chal_of(input logic [1:0] c);
        case (c)
            2'd0:    return CHAL0;
            2'd1:    return CHAL1;
            default: return CHAL2;
        endcase
    endfunction

    // The array response is asynchronous to clk_i, so it is always double-registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_meta <= '0;
            resp_sync <= '0;
        end else begin
            resp_meta <= puf_resp_i;
            resp_sync <= resp_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            tmr   <= '0;
            smp   <= '0;
            ch    <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            smp   <= smp_n;
            ch    <= ch_n;
        end
    end

    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        smp_n     = smp;
        ch_n      = ch;
        start_run = 1'b0;
        last_eval = 1'b0;
        do_vote   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n   = S_SETTLE;
                    tmr_n     = '0;
                    smp_n     = '0;
                    ch_n      = '0;
                    start_run = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    state_n = S_EVAL;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_EVAL: begin
                if (tmr == EVAL_LAST) begin
                    last_eval = 1'b1;
                    tmr_n     = '0;
                    if (smp < SMP_LAST) begin
                        smp_n   = smp + 4'd1;
                        state_n = S_SETTLE;
                    end else begin
                        state_n = S_VOTE;
                    end
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_VOTE: begin
                do_vote = 1'b1;
                tmr_n   = '0;
                if (ch < 2'd2) begin
                    ch_n    = ch + 2'd1;
                    smp_n   = '0;
                    state_n = S_SETTLE;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Majority decision and instability count over the current challenge's counters.
    always_comb begin
        vote         = '0;
        unstable_inc = '0;
        for (int i = 0; i < 32; i++) begin
            vote[i] = (cnt[i] >= MAJORITY);
            if (cnt[i] != 4'd0 && cnt[i] != SMP_ALL) begin
                unstable_inc = unstable_inc + 6'd1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            id_valid_o      <= 1'b0;
            id_o            <= '0;
            unstable_o      <= '0;
            puf_enable_o    <= 1'b0;
            puf_challenge_o <= '0;
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            busy_o          <= (state_n == S_SETTLE) || (state_n == S_EVAL) || (state_n == S_VOTE);
            done_o          <= (state_n == S_DONE);
            puf_enable_o    <= (state_n == S_EVAL);
            puf_challenge_o <= ((state_n == S_SETTLE) || (state_n == S_EVAL)) ? chal_of(ch_n) : '0;
            if (start_run) begin
                id_valid_o <= 1'b0;
                unstable_o <= '0;
                for (int i = 0; i < 32; i++) cnt[i] <= '0;
            end
            if (state_n == S_DONE) begin
                id_valid_o <= 1'b1;
            end
            if (last_eval) begin
                for (int i = 0; i < 32; i++) cnt[i] <= cnt[i] + {3'b000, resp_sync[i]};
            end
            if (do_vote) begin
                case (ch)
                    2'd0:    id_o[31:0]  <= vote;
                    2'd1:    id_o[63:32] <= vote;
                    default: id_o[95:64] <= vote;
                endcase
                unstable_o <= unstable_o + 7'(unstable_inc);
                for (int i = 0; i < 32; i++) cnt[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_puf_ctrl.sv
// tb_puf_ctrl: drives puf_ctrl with a table-driven PUF array model and checks every run
// through a scoreboard of majority-vote results computed from the sample table.
module tb_puf_ctrl;

    localparam logic [31:0] CHAL0 = 32'h5A5A_C3C3;
    localparam logic [31:0] CHAL1 = 32'h0F1E_2D3C;
    localparam logic [31:0] CHAL2 = 32'hA5F0_9E17;
    localparam int NSMP = 7;
    localparam int RUN_LEN = 256;

    typedef struct packed {
        logic [95:0] id;
        logic [6:0]  unst;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o, done_o, id_valid_o, puf_enable_o;
    logic [95:0] id_o;
    logic [6:0]  unstable_o;
    logic [31:0] puf_challenge_o;
    logic [31:0] puf_resp_i;

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int gcyc = 0;
    int last_done_cyc = 0;
    exp_t sb[$];
    logic [31:0] resp_tbl [3][NSMP];

    puf_ctrl dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .start_i(start_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .id_valid_o(id_valid_o),
        .id_o(id_o),
        .unstable_o(unstable_o),
        .puf_enable_o(puf_enable_o),
        .puf_challenge_o(puf_challenge_o),
        .puf_resp_i(puf_resp_i)
    );

    initial forever #5 clk_i = ~clk_i;
    initial forever begin
        @(posedge clk_i);
        gcyc++;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int chalIndex(input logic [31:0] c);
        if (c == CHAL0) return 0;
        if (c == CHAL1) return 1;
        if (c == CHAL2) return 2;
        return 3;
    endfunction

    // Reference: per-bit majority over the table's samples, and count of split bits.
    function automatic exp_t computeExpected();
        exp_t e;
        int n;
        e.id = '0;
        e.unst = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 32; i++) begin
                n = 0;
                for (int s = 0; s < NSMP; s++) n = n + int'(resp_tbl[c][s][i]);
                e.id[32*c+i] = (n >= (NSMP + 1) / 2);
                if (n != 0 && n != NSMP) e.unst = e.unst + 7'd1;
            end
        end
        return e;
    endfunction

    task automatic fillConst(input logic [31:0] w);
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < NSMP; s++) resp_tbl[c][s] = w;
    endtask

    task automatic fillKeyed();
        logic [31:0] ch [3];
        ch[0] = CHAL0; ch[1] = CHAL1; ch[2] = CHAL2;
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < NSMP; s++) resp_tbl[c][s] = ch[c] ^ 32'hFFFF0000;
    endtask

    task automatic fillNoisy(input int ones);
        logic [31:0] base;
        int rot;
        rot = int'($urandom_range(0, NSMP - 1));
        for (int c = 0; c < 3; c++) begin
            base = $urandom;
            if (c == 1) base[5] = 1'b0;
            for (int s = 0; s < NSMP; s++) begin
                resp_tbl[c][s] = base;
                if (c == 1 && ((s + rot) % NSMP) < ones) resp_tbl[c][s][5] = 1'b1;
            end
        end
    endtask

    task automatic fillRandom();
        logic [31:0] base;
        for (int c = 0; c < 3; c++) begin
            base = $urandom;
            for (int s = 0; s < NSMP; s++) resp_tbl[c][s] = base ^ ($urandom & $urandom & $urandom);
        end
    endtask

    task automatic issueRun();
        @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic applyStimulus();
        sb.push_back(computeExpected());
        issueRun();
    endtask

    task automatic waitDone(input int target);
        int k;
        k = 0;
        while (done_count < target && k < 1000) begin
            @(posedge clk_i);
            k++;
        end
        checkOutput("run_completes", 128'(done_count >= target), 128'(1));
    endtask

    // PUF array model: presents the table entry for the current challenge during each pulse,
    // and junk whenever enable is low.
    initial begin
        int samp_idx [3];
        int c;
        logic m_prev_en, m_prev_busy;
        puf_resp_i = '0;
        m_prev_en = 1'b0;
        m_prev_busy = 1'b0;
        for (int j = 0; j < 3; j++) samp_idx[j] = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (busy_o === 1'b1 && m_prev_busy !== 1'b1)
                for (int j = 0; j < 3; j++) samp_idx[j] = 0;
            if (puf_enable_o === 1'b1 && m_prev_en !== 1'b1) begin
                c = chalIndex(puf_challenge_o);
                if (c < 3 && samp_idx[c] < NSMP) begin
                    puf_resp_i = resp_tbl[c][samp_idx[c]];
                    samp_idx[c]++;
                end else begin
                    puf_resp_i = $urandom;
                end
            end else if (puf_enable_o !== 1'b1) begin
                puf_resp_i = $urandom;
            end
            m_prev_en = puf_enable_o;
            m_prev_busy = busy_o;
        end
    end

    // Monitor: pulse shape, challenge stability, run length, and scoreboard pop on done_o.
    initial begin
        logic prev_en, prev_busy, prev_done;
        logic [31:0] pulse_chal;
        int hi_len, lo_len, pulses, run_cyc;
        exp_t e;
        prev_en = 0; prev_busy = 0; prev_done = 0;
        hi_len = 0; lo_len = 0; pulses = 0; run_cyc = 0; pulse_chal = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni !== 1'b1) begin
                prev_en = 0; prev_busy = 0; prev_done = 0;
                hi_len = 0; lo_len = 0; pulses = 0; run_cyc = 0;
            end else begin
                if (busy_o === 1'b1 && !prev_busy) begin
                    run_cyc = 1;
                    pulses = 0;
                    lo_len = 0;
                end else if (run_cyc != 0) begin
                    run_cyc++;
                end
                if (puf_enable_o === 1'b1) begin
                    if (!prev_en) begin
                        if (pulses > 0) checkOutput("pulse_gap_ge4", 128'(lo_len >= 4), 128'(1));
                        checkOutput("pulse_chal_legal", 128'(chalIndex(puf_challenge_o) < 3), 128'(1));
                        pulse_chal = puf_challenge_o;
                        hi_len = 1;
                    end else begin
                        hi_len++;
                        checkOutput("chal_stable", 128'(puf_challenge_o), 128'(pulse_chal));
                    end
                end else begin
                    if (prev_en) begin
                        checkOutput("pulse_width", 128'(hi_len), 128'(8));
                        pulses++;
                        lo_len = 1;
                    end else begin
                        lo_len++;
                    end
                end
                if (done_o === 1'b1) begin
                    done_count++;
                    last_done_cyc = gcyc;
                    checkOutput("done_one_cycle", 128'(prev_done), 128'(0));
                    checkOutput("sb_nonempty", 128'(sb.size() > 0), 128'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("id", 128'(id_o), 128'(e.id));
                        checkOutput("unstable", 128'(unstable_o), 128'(e.unst));
                        checkOutput("id_valid_at_done", 128'(id_valid_o), 128'(1));
                        checkOutput("busy_at_done", 128'(busy_o), 128'(0));
                        checkOutput("run_length", 128'(run_cyc), 128'(RUN_LEN));
                        checkOutput("pulse_count", 128'(pulses), 128'(21));
                    end
                    run_cyc = 0;
                end
                prev_en = (puf_enable_o === 1'b1);
                prev_busy = (busy_o === 1'b1);
                prev_done = (done_o === 1'b1);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, d1, k;
        rst_ni = 1'b0;
        start_i = 1'b1;

        // Reset held with start asserted: everything stays quiet.
        fillConst(32'hDEADBEEF);
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("rst_ctrl", 128'({busy_o, done_o, id_valid_o, puf_enable_o, unstable_o}), 128'(0));
            checkOutput("rst_id", 128'(id_o), 128'(0));
            checkOutput("rst_chal", 128'(puf_challenge_o), 128'(0));
        end
        sb.push_back(computeExpected());
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        waitDone(1);
        repeat (10) @(negedge clk_i);
        checkOutput("single_run_after_reset", 128'(done_count), 128'(1));
        checkOutput("idle_after_run", 128'(busy_o), 128'(0));
        checkOutput("const_id_literal", 128'(id_o), 128'(96'hDEADBEEF_DEADBEEF_DEADBEEF));

        fillKeyed();
        applyStimulus();
        waitDone(done_count + 1);

        for (int ones = 3; ones <= 4; ones++) begin
            fillNoisy(ones);
            applyStimulus();
            waitDone(done_count + 1);
            checkOutput("noisy_bit37", 128'(id_o[37]), 128'(ones >= 4));
            checkOutput("noisy_unstable", 128'(unstable_o), 128'(1));
        end

        for (int r = 0; r < 4; r++) begin
            fillRandom();
            applyStimulus();
            waitDone(done_count + 1);
        end

        // Stray start pulses mid-run and during DONE must not start anything.
        fillRandom();
        d0 = done_count;
        applyStimulus();
        repeat (3) begin
            repeat ($urandom_range(10, 60)) @(posedge clk_i);
            #1 start_i = 1'b1;
            @(posedge clk_i);
            #1 start_i = 1'b0;
        end
        k = 0;
        while (done_o !== 1'b1 && k < 400) begin
            @(negedge clk_i);
            k++;
        end
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("start_ignored_busy", 128'(busy_o), 128'(0));
        checkOutput("start_ignored_done_cnt", 128'(done_count), 128'(d0 + 1));

        // start_i held high gives back-to-back runs.
        fillRandom();
        sb.push_back(computeExpected());
        sb.push_back(computeExpected());
        d0 = done_count;
        @(posedge clk_i);
        #1 start_i = 1'b1;
        waitDone(d0 + 1);
        d1 = last_done_cyc;
        @(negedge clk_i);
        checkOutput("b2b_idle_valid", 128'({id_valid_o, busy_o}), 128'(2'b10));
        @(negedge clk_i);
        checkOutput("b2b_restart_valid_drop", 128'({id_valid_o, busy_o}), 128'(2'b01));
        start_i = 1'b0;
        waitDone(d0 + 2);
        checkOutput("b2b_period", 128'(last_done_cyc - d1), 128'(RUN_LEN + 1));

        // Reset in the middle of an EVAL phase, then a clean run.
        fillRandom();
        issueRun();
        repeat (103) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("mid_reset_in_eval", 128'(puf_enable_o), 128'(1));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("mid_reset_outputs", 128'({puf_enable_o, busy_o, id_valid_o, done_o}), 128'(0));
        fillRandom();
        applyStimulus();
        waitDone(done_count + 1);
        repeat (3) @(negedge clk_i);
        checkOutput("sb_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
